// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared seven-segment constants for the display source sequencer
//
// Purpose: hex-to-seven-segment table, segment bit order and the active-low
// idle constants shared by the sequencer top and the hex7seg decoder.
// Ports: none (package).

package display_pkg;

  // Bit positions inside a 7-bit segment word {g,f,e,d,c,b,a}.
  typedef enum int unsigned {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  // All segments dark / all anodes off (everything is active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low gfedcba patterns, entry N is the glyph for hex digit N.
  localparam logic [15:0][6:0] HEX7SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // One-cold anode pattern for the given digit index.
  function automatic logic [3:0] an_for_digit(input logic [1:0] digit);
    return ~(4'b0001 << digit);
  endfunction

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational hex nibble to active-low seven-segment decoder
//
// Purpose: map one hex nibble to its active-low {g,f,e,d,c,b,a} pattern.
// Ports:
//   nibble  in   4  hex digit to show
//   seg_n   out  7  active-low segments {g,f,e,d,c,b,a}

module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = HEX7SEG_TABLE[nibble];

endmodule

// File: rtl/display_source_sequencer.sv
// rtl/display_source_sequencer.sv - source mux sequencer and 4-digit display scanner
//
// Purpose: steps the 32-bit source mux select on a dwell timer or a manual
// step edge (both blocked by freeze), and scans the 16-bit display half of
// the selected word across four active-low seven-segment digits.
// Ports:
//   clk               in   1      system clock, rising edge
//   rst_n             in   1      asynchronous active-low reset
//   auto_en           in   1      dwell timer advances the source
//   step              in   1      debounced step level, rising edge advances
//   freeze            in   1      hold mux_sel and the displayed value
//   value_to_display  in   16     display half from the slicer
//   mux_sel           out  SEL_W  registered source select
//   sel_changed       out  1      one-cycle pulse alongside a new mux_sel
//   an                out  4      digit enables, active-low
//   seg               out  7      segments {g,f,e,d,c,b,a}, active-low
//   dp                out  1      decimal point, low on the digit matching mux_sel

module display_source_sequencer
  import display_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int SEL_W        = 2,
  parameter int DWELL_CYCLES = 100000000,
  parameter int SCAN_CYCLES  = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             auto_en,
  input  logic             step,
  input  logic             freeze,
  input  logic [15:0]      value_to_display,
  output logic [SEL_W-1:0] mux_sel,
  output logic             sel_changed,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int SCAN_W  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  logic [DWELL_W-1:0] dwell_cnt;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         digit;
  logic [15:0]        snapshot;
  logic               step_q;

  logic               step_rise;
  logic               dwell_tc;
  logic               scan_tc;
  logic               adv;
  logic [3:0]         nibble;
  logic [6:0]         seg_next;
  logic               dp_next;

  assign step_rise = step & ~step_q;
  assign dwell_tc  = (dwell_cnt == DWELL_W'(DWELL_CYCLES - 1));
  assign scan_tc   = (scan_cnt == SCAN_W'(SCAN_CYCLES - 1));
  // A step edge coinciding with the dwell terminal count is still one advance.
  assign adv       = ~freeze & (step_rise | (auto_en & dwell_tc));

  // Source selection and dwell timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_sel     <= '0;
      sel_changed <= 1'b0;
      dwell_cnt   <= '0;
      step_q      <= 1'b0;
    end else begin
      // Tracked even while frozen so a step held across freeze is not replayed.
      step_q      <= step;
      sel_changed <= adv;
      if (adv) begin
        mux_sel   <= (mux_sel == SEL_W'(NUM_SRC - 1)) ? '0 : mux_sel + SEL_W'(1);
        dwell_cnt <= '0;
      end else if (auto_en && !freeze) begin
        dwell_cnt <= dwell_cnt + DWELL_W'(1);
      end
    end
  end

  // Display snapshot and digit scan; the scan free-runs regardless of mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snapshot <= '0;
      scan_cnt <= '0;
      digit    <= '0;
    end else begin
      if (!freeze) begin
        snapshot <= value_to_display;
      end
      if (scan_tc) begin
        scan_cnt <= '0;
        digit    <= digit + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
    end
  end

  always_comb begin
    nibble = snapshot[3:0];
    case (digit)
      2'd0: nibble = snapshot[3:0];
      2'd1: nibble = snapshot[7:4];
      2'd2: nibble = snapshot[11:8];
      2'd3: nibble = snapshot[15:12];
      default: nibble = snapshot[3:0];
    endcase
  end

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg_n  (seg_next)
  );

  assign dp_next = ~(32'(digit) == 32'(mux_sel));

  // Registered pin drivers, one cycle behind digit/snapshot/mux_sel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_for_digit(digit);
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_display_source_sequencer.sv
// tb/tb_display_source_sequencer.sv - self-checking bench for display_source_sequencer

module tb_display_source_sequencer;

  localparam int DW = 8;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        auto_en;
  logic        step;
  logic        freeze;
  logic [15:0] value_to_display;

  logic [1:0]  sel_o [2];
  logic        chg_o [2];
  logic [3:0]  an_o  [2];
  logic [6:0]  seg_o [2];
  logic        dp_o  [2];

  always #5 clk = ~clk;

  display_source_sequencer #(
    .NUM_SRC(3), .SEL_W(2), .DWELL_CYCLES(DW), .SCAN_CYCLES(SC)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .auto_en(auto_en), .step(step), .freeze(freeze),
    .value_to_display(value_to_display), .mux_sel(sel_o[0]), .sel_changed(chg_o[0]),
    .an(an_o[0]), .seg(seg_o[0]), .dp(dp_o[0])
  );

  display_source_sequencer #(
    .NUM_SRC(4), .SEL_W(2), .DWELL_CYCLES(DW), .SCAN_CYCLES(SC)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .auto_en(auto_en), .step(step), .freeze(freeze),
    .value_to_display(value_to_display), .mux_sel(sel_o[1]), .sel_changed(chg_o[1]),
    .an(an_o[1]), .seg(seg_o[1]), .dp(dp_o[1])
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: per-instance selection state, shared display state.
  int          nsrc [2] = '{3, 4};
  int          m_sel   [2];
  int          m_dwell [2];
  logic        m_chg   [2];
  logic [3:0]  m_an    [2];
  logic [6:0]  m_seg   [2];
  logic        m_dp    [2];
  logic        m_sprev;
  logic [15:0] m_snap;
  int          m_k;     // clock edges seen since reset release

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sel[i] = 0; m_dwell[i] = 0; m_chg[i] = 1'b0;
      m_an[i] = 4'hF; m_seg[i] = 7'h7F; m_dp[i] = 1'b1;
    end
    m_sprev = 1'b0;
    m_snap  = 16'h0;
    m_k     = 0;
  endtask

  // Evaluates one clock edge from the input values present just before it.
  task automatic model_edge();
    int   dig;
    logic rise;
    logic adv;
    logic [3:0] nib;
    if (!rst_n) begin
      model_reset();
      return;
    end
    dig  = (m_k / SC) % 4;
    rise = step && !m_sprev;
    nib  = 4'(m_snap >> (4 * dig));
    for (int i = 0; i < 2; i++) begin
      adv = !freeze && (rise || (auto_en && m_dwell[i] == DW - 1));
      m_an[i]  = ~(4'b0001 << dig);
      m_seg[i] = hex_tab[nib];
      m_dp[i]  = !(dig == m_sel[i]);
      m_chg[i] = adv;
      if (adv) begin
        m_sel[i]   = (m_sel[i] + 1) % nsrc[i];
        m_dwell[i] = 0;
      end else if (auto_en && !freeze) begin
        m_dwell[i] = m_dwell[i] + 1;
      end
    end
    if (!freeze) m_snap = value_to_display;
    m_sprev = step;
    m_k     = m_k + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
      end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d.mux_sel", i),     32'(sel_o[i]), 32'(m_sel[i]));
      check($sformatf("dut%0d.sel_changed", i), 32'(chg_o[i]), 32'(m_chg[i]));
      check($sformatf("dut%0d.an", i),          32'(an_o[i]),  32'(m_an[i]));
      check($sformatf("dut%0d.seg", i),         32'(seg_o[i]), 32'(m_seg[i]));
      check($sformatf("dut%0d.dp", i),          32'(dp_o[i]),  32'(m_dp[i]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; auto_en = 1'b0; step = 1'b0; freeze = 1'b0;
    value_to_display = 16'h0000;
    model_reset();
    repeat (2) cyc();

    // Release: first edge lights digit 0.
    rst_n = 1'b1;
    cyc();
    check("release.an", 32'(an_o[0]), 32'h0000000E);

    // Auto cycling with a fixed value so every digit glyph is visible.
    auto_en = 1'b1;
    value_to_display = 16'h4567;
    repeat (40) cyc();

    // Manual stepping: four edges, each held high five cycles.
    auto_en = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step = 1'b1;
      repeat (5) cyc();
      step = 1'b0;
      repeat (3) cyc();
    end
    check("manual.wrap4", 32'(sel_o[1]), 32'(m_sel[1]));

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async.mux_sel", 32'(sel_o[1]), 32'h0);
    check("async.an",      32'(an_o[1]),  32'hF);
    check("async.seg",     32'(seg_o[1]), 32'h7F);
    check("async.dp",      32'(dp_o[1]),  32'h1);
    cyc();

    // Step edge landing on the dwell terminal count: one advance, dwell restarts.
    rst_n = 1'b1;
    auto_en = 1'b1;
    value_to_display = 16'hC0DE;
    repeat (DW - 1) cyc();
    step = 1'b1;
    cyc();
    check("simul.sel", 32'(sel_o[1]), 32'h1);
    step = 1'b0;
    repeat (DW + 4) cyc();
    check("simul.next", 32'(sel_o[1]), 32'h2);

    // Freeze holds the displayed value and ignores step edges.
    auto_en = 1'b0;
    value_to_display = 16'h89AB;
    repeat (3) cyc();
    freeze = 1'b1;
    value_to_display = 16'h0123;
    repeat (20) cyc();
    step = 1'b1;
    repeat (3) cyc();
    step = 1'b0;
    repeat (2) cyc();
    freeze = 1'b0;
    repeat (20) cyc();

    // Randomized operation against the model.
    auto_en = 1'b1;
    repeat (800) begin
      if ($urandom_range(0, 15) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 3) == 0)  step = ~step;
      if ($urandom_range(0, 15) == 0) freeze = ~freeze;
      if ($urandom_range(0, 2) == 0)  value_to_display = 16'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
